// File: rtl/param_sipo_deser_if.sv
// rtl/param_sipo_deser_if.sv - serial-in and held-word signals of param_sipo_deser
// Optional parity_err signal present when SIPO_PARITY_EN is defined.
interface param_sipo_deser_if #(
    parameter int WIDTH = 8
);
`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);

    logic             shift_en;
    logic             data_in;
    logic             msb_first;
    logic             clr;
    logic             word_ack;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             overrun;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        output shift_en, data_in, msb_first, clr, word_ack,
`ifdef SIPO_PARITY_EN
        input  parity_err,
`endif
        input  q, bit_cnt, word_out, word_valid, overrun
    );

    modport slave (
        input  shift_en, data_in, msb_first, clr, word_ack,
`ifdef SIPO_PARITY_EN
        output parity_err,
`endif
        output q, bit_cnt, word_out, word_valid, overrun
    );
endinterface

// File: rtl/param_sipo_deser.sv
// rtl/param_sipo_deser.sv - parametrised SIPO deserialiser with held word, valid/ack and overrun
// Define SIPO_PARITY_EN to append a parity bit to each frame and report PARITY_ERR.
module param_sipo_deser #(
    parameter int WIDTH      = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              resetn,
    param_sipo_deser_if.slave bus
);
`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int            CW   = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             overrun;
    logic             complete;
    logic             data_shift;

    always_comb begin
        complete = bus.shift_en && (bit_cnt == LAST);
`ifdef SIPO_PARITY_EN
        // The parity bit goes to its own check, never into the data register.
        data_shift = bus.shift_en && (bit_cnt != LAST);
`else
        data_shift = bus.shift_en;
`endif
        q_next = q;
        if (data_shift) begin
            if (bus.msb_first)
                q_next = {q[WIDTH-2:0], bus.data_in};
            else
                q_next = {bus.data_in, q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q          <= '0;
            bit_cnt    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (bus.clr) begin
            q          <= '0;
            bit_cnt    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            q <= q_next;
            if (bus.shift_en)
                bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
            if (complete) begin
                // An ack on the completing edge consumes the old word, so no overrun.
                word_out   <= q_next;
                word_valid <= 1'b1;
                if (word_valid && !bus.word_ack)
                    overrun <= 1'b1;
            end else if (bus.word_ack) begin
                word_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    logic parity_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            parity_err <= 1'b0;
        else if (bus.clr)
            parity_err <= 1'b0;
        else if (complete)
            parity_err <= ((^q) ^ bus.data_in) != (ODD_PARITY != 0);
    end

    assign bus.parity_err = parity_err;
`else
    wire unused_odd_parity = (ODD_PARITY != 0);
`endif

    assign bus.q          = q;
    assign bus.bit_cnt    = bit_cnt;
    assign bus.word_out   = word_out;
    assign bus.word_valid = word_valid;
    assign bus.overrun    = overrun;

endmodule

// File: tb/tb_param_sipo_deser.sv
// tb/tb_param_sipo_deser.sv - self-checking bench for param_sipo_deser
// Directed scenarios plus randomized traffic against a frame-level reference model.
module tb_param_sipo_deser;
    localparam int W   = 8;
    localparam int ODD = 0;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    localparam int CW = $clog2(FRAME);

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp  = 0;
    int   n_fail = 0;

    param_sipo_deser_if #(.WIDTH(W)) bus ();

    param_sipo_deser #(.WIDTH(W), .ODD_PARITY(ODD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_q;
    logic [W-1:0] m_word;
    int           m_n;
    bit           m_valid;
    bit           m_ovr;
    bit           m_perr;
    bit           m_bits[$];

    function automatic logic dut_perr();
`ifdef SIPO_PARITY_EN
        return bus.parity_err;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_clear();
        m_q     = '0;
        m_word  = '0;
        m_n     = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
        m_bits.delete();
    endfunction

    // Word from the frame's received bits by positional weight.
    function automatic logic [W-1:0] assemble(input bit mf);
        int w = 0;
        for (int i = 0; i < W; i++)
            if (m_bits[i]) w += mf ? (1 << (W - 1 - i)) : (1 << i);
        return W'(w);
    endfunction

    function automatic void model_edge(input bit se, input bit di, input bit mf,
                                       input bit cl, input bit ack);
        bit comp = 1'b0;
        if (cl) begin
            model_clear();
            return;
        end
        if (se) begin
            if (m_n < W) begin
                m_bits.push_back(di);
                if (mf) m_q = W'(int'(m_q) * 2 + int'(di));
                else    m_q = W'(int'(m_q) / 2 + (di ? (1 << (W - 1)) : 0));
            end
            m_n++;
            if (m_n == FRAME) begin
                comp = 1'b1;
                if (m_valid && !ack) m_ovr = 1'b1;
                m_word  = assemble(mf);
                m_valid = 1'b1;
`ifdef SIPO_PARITY_EN
                m_perr  = ((($countones(m_word) + int'(di)) % 2) != ODD);
`endif
                m_n = 0;
                m_bits.delete();
            end
        end
        if (!comp && ack) m_valid = 1'b0;
    endfunction

    task automatic tick(input bit se, input bit di, input bit mf, input bit cl, input bit ack);
        bus.shift_en  = se;
        bus.data_in   = di;
        bus.msb_first = mf;
        bus.clr       = cl;
        bus.word_ack  = ack;
        @(posedge clk);
        model_edge(se, di, mf, cl, ack);
        @(negedge clk);
        bus.shift_en = 1'b0;
        bus.clr      = 1'b0;
        bus.word_ack = 1'b0;
    endtask

    // Serial order is seq[7] first; parity bit (if any) makes a correct frame.
    task automatic send_serial(input logic [7:0] seq, input bit mf, input bit ack_last);
        for (int i = 0; i < 8; i++)
            tick(1'b1, seq[7-i], mf, 1'b0, ack_last && (FRAME == 8) && (i == 7));
`ifdef SIPO_PARITY_EN
        tick(1'b1, (^seq) ^ (ODD != 0), mf, 1'b0, ack_last);
`endif
    endtask

    task automatic test_reset();
        bus.shift_en = 0; bus.data_in = 0; bus.msb_first = 1; bus.clr = 0; bus.word_ack = 0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_clear();
        n_cmp++;
        if ({bus.q, bus.bit_cnt, bus.word_out, bus.word_valid, bus.overrun, dut_perr()} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: q=%h cnt=%0d word=%h valid=%b ovr=%b, required all 0",
                     bus.q, bus.bit_cnt, bus.word_out, bus.word_valid, bus.overrun);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.q !== W'(7) || bus.bit_cnt !== CW'(3)) begin
            n_fail++;
            $display("FAIL pre_reset_shift: q=%h cnt=%0d, required q=07 cnt=3", bus.q, bus.bit_cnt);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.q, bus.bit_cnt, bus.word_out, bus.word_valid, bus.overrun, dut_perr()} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: q=%h cnt=%0d valid=%b, required all 0 before clock edge",
                     bus.q, bus.bit_cnt, bus.word_valid);
        end
        #1 resetn = 1'b1;
        model_clear();
        @(negedge clk);
        for (int i = 0; i < FRAME - 1; i++) tick(1'b1, 1'($urandom_range(1)), 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_partial_frame: valid=%b, required 0", bus.word_valid);
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.word_valid !== 1'b1 || bus.bit_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_full_frame: valid=%b cnt=%0d, required valid=1 cnt=0",
                     bus.word_valid, bus.bit_cnt);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] seq = 8'h1E;
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, seq[7-i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (bus.q !== 8'h00 || bus.bit_cnt !== CW'(3)) begin
                n_fail++;
                $display("FAIL shift_gap_hold: q=%h cnt=%0d, required q=00 cnt=3", bus.q, bus.bit_cnt);
            end
        end
        for (int i = 3; i < 8; i++) tick(1'b1, seq[7-i], 1'b1, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
        tick(1'b1, (^seq) ^ (ODD != 0), 1'b1, 1'b0, 1'b0);
`endif
        n_cmp++;
        if (bus.word_out !== 8'h1E || bus.word_valid !== 1'b1 || bus.bit_cnt !== '0) begin
            n_fail++;
            $display("FAIL msb_first_word: word=%h valid=%b cnt=%0d, required 1e 1 0",
                     bus.word_out, bus.word_valid, bus.bit_cnt);
        end
    endtask

    task automatic test_lsb_first_ack();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_serial(8'h1E, 1'b0, 1'b0);
        n_cmp++;
        if (bus.word_out !== 8'h78 || bus.word_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_first_word: word=%h valid=%b, required 78 1", bus.word_out, bus.word_valid);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.word_out !== 8'h78 || bus.word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_clears_valid: word=%h valid=%b, required 78 0", bus.word_out, bus.word_valid);
        end
    endtask

    task automatic test_overrun();
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_serial(8'h1E, 1'b1, 1'b0);
        send_serial(8'hA5, 1'b1, 1'b0);
        n_cmp++;
        if (bus.word_out !== 8'hA5 || bus.word_valid !== 1'b1 || bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: word=%h valid=%b ovr=%b, required a5 1 1",
                     bus.word_out, bus.word_valid, bus.overrun);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.word_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: valid=%b ovr=%b, required 0 1", bus.word_valid, bus.overrun);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bus.overrun !== 1'b0 || bus.word_out !== 8'h00 || bus.word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_outputs: ovr=%b word=%h valid=%b, required 0 00 0",
                     bus.overrun, bus.word_out, bus.word_valid);
        end
    endtask

    task automatic test_ack_on_completion();
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_serial(8'h3C, 1'b1, 1'b0);
        send_serial(8'hC3, 1'b1, 1'b1);
        n_cmp++;
        if (bus.word_out !== 8'hC3 || bus.word_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_on_completion: word=%h valid=%b ovr=%b, required c3 1 0",
                     bus.word_out, bus.word_valid, bus.overrun);
        end
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        logic [7:0] seq = 8'h1E;
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, seq[7-i], 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.word_valid !== 1'b1 || bus.parity_err !== 1'b0 || bus.bit_cnt !== '0
            || bus.word_out !== 8'h1E) begin
            n_fail++;
            $display("FAIL parity_good: valid=%b perr=%b cnt=%0d word=%h, required 1 0 0 1e",
                     bus.word_valid, bus.parity_err, bus.bit_cnt, bus.word_out);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, seq[7-i], 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.parity_err !== 1'b1 || bus.word_out !== 8'h1E) begin
            n_fail++;
            $display("FAIL parity_bad: perr=%b word=%h, required 1 1e", bus.parity_err, bus.word_out);
        end
    endtask
`endif

    task automatic test_random();
        bit mf = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 400; c++) begin
            bit se, di, ack, cl;
            if (m_n == 0) mf = 1'($urandom_range(1));
            se  = ($urandom_range(3) != 0);
            di  = 1'($urandom_range(1));
            ack = ($urandom_range(5) == 0);
            cl  = ($urandom_range(79) == 0);
            tick(se, di, mf, cl, ack);
            n_cmp++;
            if (bus.q !== m_q || bus.bit_cnt !== CW'(m_n) || bus.word_out !== m_word
                || bus.word_valid !== m_valid || bus.overrun !== m_ovr || dut_perr() !== m_perr) begin
                n_fail++;
                $display("FAIL random_cycle%0d: q=%h cnt=%0d word=%h valid=%b ovr=%b perr=%b, required q=%h cnt=%0d word=%h valid=%b ovr=%b perr=%b",
                         c, bus.q, bus.bit_cnt, bus.word_out, bus.word_valid, bus.overrun, dut_perr(),
                         m_q, m_n, m_word, m_valid, m_ovr, m_perr);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_msb_first();
        test_lsb_first_ack();
        test_overrun();
        test_ack_on_completion();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
